// File: rtl/mio_bus_responder_if.sv
// CPU-side memory/IO handshake bundle for mio_bus_responder.
// The CPU holds CPU_MIO high until MIO_ready is sampled high.
interface mio_bus_responder_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] addr_bus;
    logic [31:0] Data_write;
    logic [31:0] Data_read;
    logic        MIO_ready;

    modport master (output CPU_MIO, mem_w, addr_bus, Data_write,
                    input  Data_read, MIO_ready);
    modport slave  (input  CPU_MIO, mem_w, addr_bus, Data_write,
                    output Data_read, MIO_ready);
endinterface

// File: rtl/mio_bus_responder.sv
// CPU memory/IO responder: decodes RAM, GPIO and switch regions and completes each access with a one-cycle MIO_ready.
// Optional macro MIO_BUSERR_EN adds a bus_err output for unmapped accesses and switch writes.
module mio_bus_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int GPIO_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    mio_bus_responder_if.slave bus,
    output logic              ram_we,
    output logic [9:0]        ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       switches,
    output logic [GPIO_W-1:0] gpio_out
`ifdef MIO_BUSERR_EN
    ,
    output logic              bus_err
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic [1:0] {RGN_RAM, RGN_GPIO, RGN_SW, RGN_NONE} region_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t  state;
    region_t region;
    logic    wr;
    logic [3:0] wait_cnt;

    function automatic region_t decode(input logic [3:0] nib);
        case (nib)
            4'h0:    return RGN_RAM;
            4'hE:    return RGN_GPIO;
            4'hF:    return RGN_SW;
            default: return RGN_NONE;
        endcase
    endfunction

    // Only the region and word address of the latched address are ever used,
    // so those are what get stored; ram_addr/ram_din are the latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            region        <= RGN_RAM;
            wr            <= 1'b0;
            wait_cnt      <= 4'd0;
            ram_addr      <= 10'd0;
            ram_din       <= 32'h0;
            ram_we        <= 1'b0;
            gpio_out      <= '0;
            bus.Data_read <= 32'h0;
            bus.MIO_ready <= 1'b0;
`ifdef MIO_BUSERR_EN
            bus_err       <= 1'b0;
`endif
        end else begin
            bus.MIO_ready <= 1'b0;
            ram_we        <= 1'b0;
`ifdef MIO_BUSERR_EN
            bus_err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.CPU_MIO) begin
                        region   <= decode(bus.addr_bus[31:28]);
                        wr       <= bus.mem_w;
                        ram_addr <= bus.addr_bus[11:2];
                        ram_din  <= bus.Data_write;
                        // Strobe is raised here so it is high for exactly the ACCESS cycle
                        ram_we   <= bus.mem_w && (decode(bus.addr_bus[31:28]) == RGN_RAM);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (region == RGN_RAM) begin
                        if (WAIT_CYCLES > 0) begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= WAIT;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        if (region == RGN_GPIO && wr)
                            gpio_out <= ram_din[GPIO_W-1:0];
                        state <= DONE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= DONE;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                DONE: begin
                    bus.MIO_ready <= 1'b1;
                    if (!wr) begin
                        case (region)
                            RGN_RAM:  bus.Data_read <= ram_dout;
                            RGN_GPIO: bus.Data_read <= 32'(gpio_out);
                            RGN_SW:   bus.Data_read <= {16'h0, switches};
                            default:  bus.Data_read <= 32'h0;
                        endcase
                    end
`ifdef MIO_BUSERR_EN
                    bus_err <= (region == RGN_NONE) || (region == RGN_SW && wr);
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed self-checking bench: one DUT with WAIT_CYCLES=2, a second with WAIT_CYCLES=0 for back-to-back reads.
module tb_mio_bus_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT with default wait states
    mio_bus_responder_if bus();
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic [15:0] switches;
    logic [15:0] gpio_out;
    logic        bus_err;

    mio_bus_responder #(.WAIT_CYCLES(2), .GPIO_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .switches(switches), .gpio_out(gpio_out)
`ifdef MIO_BUSERR_EN
        , .bus_err(bus_err)
`endif
    );

    // DUT with no wait states
    mio_bus_responder_if bus0();
    logic        ram_we0;
    logic [9:0]  ram_addr0;
    logic [31:0] ram_din0, ram_dout0;
    logic [15:0] gpio_out0;
    logic        bus_err0;

    mio_bus_responder #(.WAIT_CYCLES(0), .GPIO_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_dout(ram_dout0),
        .switches(switches), .gpio_out(gpio_out0)
`ifdef MIO_BUSERR_EN
        , .bus_err(bus_err0)
`endif
    );

    // Synchronous-read RAM models
    logic [31:0] mem  [1024];
    logic [31:0] mem0 [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end
    always @(posedge clk) begin
        if (ram_we0) mem0[ram_addr0] <= ram_din0;
        ram_dout0 <= mem0[ram_addr0];
    end

    int          we_cnt = 0;
    logic [9:0]  we_addr = '0;
    logic [31:0] we_data = '0;
    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= ram_addr;
            we_data <= ram_din;
        end
    end

`ifndef MIO_BUSERR_EN
    assign bus_err  = 1'b0;
    assign bus_err0 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: after the acceptance edge the request lines are scrambled,
    // which the responder must ignore. lat = edges from acceptance to MIO_ready.
    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic err);
        @(negedge clk);
        bus.CPU_MIO = 1'b1; bus.mem_w = w; bus.addr_bus = a; bus.Data_write = d;
        @(posedge clk);
        #1;
        bus.CPU_MIO = 1'b0; bus.mem_w = ~w;
        bus.addr_bus = 32'h5FFF_FFFC; bus.Data_write = 32'h0BAD_0BAD;
        lat = 0;
        err = 1'b0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.MIO_ready) break;
        end
        if (!bus.MIO_ready) chk("ready_timeout", {31'h0, bus.MIO_ready}, 32'h1);
        err = bus_err;
        @(posedge clk);
        #1;
        chk("ready_one_cycle", {31'h0, bus.MIO_ready}, 32'h0);
    endtask

    int   lat;
    logic err;
    int   we_before;
    int   pulses;
    int   pulse_cyc [4];
    logic [31:0] pulse_dat [4];

    initial begin
        bus.CPU_MIO = 1'b0; bus.mem_w = 1'b0; bus.addr_bus = '0; bus.Data_write = '0;
        bus0.CPU_MIO = 1'b0; bus0.mem_w = 1'b0; bus0.addr_bus = '0; bus0.Data_write = '0;
        switches = 16'h1234;
        mem0[1] = 32'hA1A1_0001;
        mem0[2] = 32'hB2B2_0002;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",     {31'h0, bus.MIO_ready}, 32'h0);
        chk("rst_ram_we",    {31'h0, ram_we},        32'h0);
        chk("rst_data_read", bus.Data_read,          32'h0);
        chk("rst_gpio",      {16'h0, gpio_out},      32'h0);
        rst = 1'b0;

        // RAM write then read
        we_before = we_cnt;
        acc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, err);
        chk("ramw_lat",     lat,                 4);
        chk("ramw_we_cnt",  we_cnt - we_before,  1);
        chk("ramw_we_addr", {22'h0, we_addr},    32'h4);
        chk("ramw_we_data", we_data,             32'hDEAD_BEEF);
        chk("ramw_no_dr",   bus.Data_read,       32'h0);
        acc(1'b0, 32'h0000_0010, 32'h0, lat, err);
        chk("ramr_lat",     lat,                 4);
        chk("ramr_data",    bus.Data_read,       32'hDEAD_BEEF);
        chk("ramr_no_we",   we_cnt - we_before,  1);

        // GPIO write/read
        acc(1'b1, 32'hE000_0000, 32'h0001_A5A5, lat, err);
        chk("gpiow_lat",    lat,                 2);
        chk("gpiow_out",    {16'h0, gpio_out},   32'h0000_A5A5);
        chk("gpiow_no_dr",  bus.Data_read,       32'hDEAD_BEEF);
`ifdef MIO_BUSERR_EN
        chk("gpiow_err",    {31'h0, err},        32'h0);
`endif
        acc(1'b0, 32'hE000_0000, 32'h0, lat, err);
        chk("gpior_lat",    lat,                 2);
        chk("gpior_data",   bus.Data_read,       32'h0000_A5A5);

        // Switch read, then an ignored switch write
        acc(1'b0, 32'hF000_0000, 32'h0, lat, err);
        chk("swr_lat",      lat,                 2);
        chk("swr_data",     bus.Data_read,       32'h0000_1234);
`ifdef MIO_BUSERR_EN
        chk("swr_err",      {31'h0, err},        32'h0);
`endif
        acc(1'b1, 32'hF000_0000, 32'h0000_FFFF, lat, err);
        chk("sww_gpio",     {16'h0, gpio_out},   32'h0000_A5A5);
        chk("sww_no_dr",    bus.Data_read,       32'h0000_1234);
`ifdef MIO_BUSERR_EN
        chk("sww_err",      {31'h0, err},        32'h1);
`endif

        // Unmapped write is dropped, unmapped read returns zero
        acc(1'b1, 32'h5000_0000, 32'h0000_3C3C, lat, err);
        chk("unw_gpio",     {16'h0, gpio_out},   32'h0000_A5A5);
        acc(1'b0, 32'h5000_0000, 32'h0, lat, err);
        chk("unr_lat",      lat,                 2);
        chk("unr_data",     bus.Data_read,       32'h0);
`ifdef MIO_BUSERR_EN
        chk("unr_err",      {31'h0, err},        32'h1);
`endif

        // Reset in the middle of a RAM write's wait phase
        acc(1'b0, 32'h0000_0010, 32'h0, lat, err);
        chk("pre_rst_data", bus.Data_read,       32'hDEAD_BEEF);
        @(negedge clk);
        bus.CPU_MIO = 1'b1; bus.mem_w = 1'b1; bus.addr_bus = 32'h0000_0020; bus.Data_write = 32'h1111_1111;
        @(posedge clk);
        #1;
        bus.CPU_MIO = 1'b0;
        chk("mid_access_we", {31'h0, ram_we},    32'h1);
        @(posedge clk);
        #1;
        chk("mid_wait_we",   {31'h0, ram_we},    32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_ready", {31'h0, bus.MIO_ready}, 32'h0);
        chk("midrst_we",    {31'h0, ram_we},        32'h0);
        chk("midrst_gpio",  {16'h0, gpio_out},      32'h0);
        chk("midrst_dr",    bus.Data_read,          32'h0);
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.MIO_ready) pulses++;
        end
        chk("midrst_no_ready", pulses, 0);

        // Back-to-back reads with CPU_MIO held high and no wait states
        @(negedge clk);
        bus0.CPU_MIO = 1'b1; bus0.mem_w = 1'b0; bus0.addr_bus = 32'h0000_0004;
        pulses = 0;
        for (int cyc = 1; cyc <= 40 && pulses < 4; cyc++) begin
            @(posedge clk);
            #1;
            if (bus0.MIO_ready) begin
                pulse_cyc[pulses] = cyc;
                pulse_dat[pulses] = bus0.Data_read;
                pulses++;
                bus0.addr_bus = (bus0.addr_bus == 32'h4) ? 32'h8 : 32'h4;
            end
        end
        bus0.CPU_MIO = 1'b0;
        chk("b2b_pulses", pulses, 4);
        if (pulses == 4) begin
            chk("b2b_first", pulse_cyc[0], 3);
            chk("b2b_gap1",  pulse_cyc[1] - pulse_cyc[0], 3);
            chk("b2b_gap2",  pulse_cyc[2] - pulse_cyc[1], 3);
            chk("b2b_gap3",  pulse_cyc[3] - pulse_cyc[2], 3);
            chk("b2b_d0",    pulse_dat[0], 32'hA1A1_0001);
            chk("b2b_d1",    pulse_dat[1], 32'hB2B2_0002);
            chk("b2b_d2",    pulse_dat[2], 32'hA1A1_0001);
            chk("b2b_d3",    pulse_dat[3], 32'hB2B2_0002);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
